// File: rtl/mem_pkg.sv
// Shared types and helpers for the boot-loading CPU memory.
package mem_pkg;

  // BOOT copies the ROM image into RAM; RUN serves CPU requests until reset.
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int MAX_LANES  = 32;

  // One-hot byte-lane enable for a byte write; lanes beyond the word get nothing.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] lane,
                                                     input int        lanes);
    logic [MAX_LANES-1:0] m;
    m = '0;
    if (int'(lane) < lanes) m[lane] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/boot_rom.sv
// Boot image ROM: the LED test program copied into RAM after every reset.
// Indices at or beyond BOOT_WORDS read as zero.
module boot_rom
  import mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BOOT_WORDS = 17,
  parameter int IW         = 11
) (
  input  logic [IW-1:0]     idx,
  output logic [DATA_W-1:0] word
);

  logic [31:0] img;

  // Image lookup; words past the end of the program read as zero.
  always_comb begin
    img = 32'h0000_0000;
    case (int'(idx))
      0:  img = 32'h0C00_0000;
      1:  img = 32'h0C20_0001;
      2:  img = 32'h0C40_00FF;
      3:  img = 32'h1401_0000;
      4:  img = 32'h0C60_0000;
      5:  img = 32'h2063_0001;
      6:  img = 32'h1C62_FFFE;
      7:  img = 32'h2021_0001;
      8:  img = 32'h1401_0000;
      9:  img = 32'h0C60_0000;
      10: img = 32'h2063_0001;
      11: img = 32'h1C62_FFFE;
      12: img = 32'h2821_0001;
      13: img = 32'h1401_0000;
      14: img = 32'h1C20_FFF3;
      15: img = 32'h0800_0000;
      16: img = 32'hFFF9_FFF4;
      default: img = 32'h0000_0000;
    endcase
    if (int'(idx) >= BOOT_WORDS) img = 32'h0000_0000;
    word = DATA_W'(img);
  end

endmodule

// File: rtl/boot_memory.sv
// Word-addressed synchronous RAM between the CPU and the memory array.
// After reset a sequential loader copies the boot ROM image into the
// first BOOT_WORDS words; CPU requests are served only once ready is high.
//
//   state | meaning
//   BOOT  | copying boot_rom[cnt] -> ram[cnt], one word per cycle
//   RUN   | ready; reads/writes accepted every cycle until reset
module boot_memory
  import mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = 1024,
  parameter int BOOT_WORDS = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [31:0]       addr_read,
  input  logic              wr_req,
  input  logic [31:0]       addr_write,
  input  logic [DATA_W-1:0] data_write,
  input  logic              write_byte,
  output logic [DATA_W-1:0] out,
  output logic              rd_valid,
  output logic              written,
  output logic              ready,
  output logic              range_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = DATA_W / 8;
  // Counter is one bit wider than the index so BOOT_WORDS == DEPTH never wraps.
  localparam logic [AW:0] CNT_LAST = (AW + 1)'(BOOT_WORDS - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nx;
  logic [AW:0]       cnt, cnt_nx;
  logic              run;

  logic [AW-1:0]     rd_idx, wr_idx;
  logic              rd_oor, wr_oor;

  logic [DATA_W-1:0] rom_word;
  logic [LANES-1:0]  byte_en;

  logic              ram_we;
  logic [AW-1:0]     ram_idx;
  logic [DATA_W-1:0] ram_data;
  logic [LANES-1:0]  ram_be;

  logic [1:0]        addr_read_unused;

  assign addr_read_unused = addr_read[1:0];

  assign run    = (state == RUN);
  assign ready  = run;

  assign rd_idx = addr_read[AW+1:2];
  assign wr_idx = addr_write[AW+1:2];
  assign rd_oor = {2'b00, addr_read[31:2]}  >= 32'(DEPTH);
  assign wr_oor = {2'b00, addr_write[31:2]} >= 32'(DEPTH);

  assign byte_en = LANES'(lane_mask(addr_write[1:0], LANES));

  boot_rom #(
    .DATA_W    (DATA_W),
    .BOOT_WORDS(BOOT_WORDS),
    .IW        (AW + 1)
  ) u_boot_rom (
    .idx (cnt),
    .word(rom_word)
  );

  // State and boot counter registers; reset restarts the copy from word 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state and the single RAM write port: loader in BOOT, CPU in RUN.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ram_we   = 1'b0;
    ram_idx  = cnt[AW-1:0];
    ram_data = rom_word;
    ram_be   = '1;
    case (state)
      BOOT: begin
        ram_we = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nx = RUN;
      end
      RUN: begin
        if (wr_req && !wr_oor) begin
          ram_we  = 1'b1;
          ram_idx = wr_idx;
          if (write_byte) begin
            ram_data = {LANES{data_write[7:0]}};
            ram_be   = byte_en;
          end else begin
            ram_data = data_write;
          end
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  // RAM array with per-byte enables; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (ram_be[b]) mem[ram_idx][b*8 +: 8] <= ram_data[b*8 +: 8];
      end
    end
  end

  // Registered read port and status pulses; the read samples pre-write data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out       <= '0;
      rd_valid  <= 1'b0;
      written   <= 1'b0;
      range_err <= 1'b0;
    end else begin
      rd_valid  <= run && rd_req;
      written   <= run && wr_req;
      range_err <= run && ((rd_req && rd_oor) || (wr_req && wr_oor));
      if (run && rd_req) begin
        if (rd_oor) out <= '0;
        else        out <= mem[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_boot_memory.sv
// Directed + randomized bench for boot_memory with a word-array reference model.
module tb_boot_memory;

  localparam int DEPTH = 1024;
  localparam int BOOT  = 17;

  logic        clock, reset;
  logic        rd_req, wr_req, write_byte;
  logic [31:0] addr_read, addr_write, data_write;
  logic [31:0] out;
  logic        rd_valid, written, ready, range_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] image [BOOT] = '{
    32'h0C00_0000, 32'h0C20_0001, 32'h0C40_00FF, 32'h1401_0000,
    32'h0C60_0000, 32'h2063_0001, 32'h1C62_FFFE, 32'h2021_0001,
    32'h1401_0000, 32'h0C60_0000, 32'h2063_0001, 32'h1C62_FFFE,
    32'h2821_0001, 32'h1401_0000, 32'h1C20_FFF3, 32'h0800_0000,
    32'hFFF9_FFF4
  };

  logic [31:0] model [32];

  boot_memory #(.DATA_W(32), .DEPTH(DEPTH), .BOOT_WORDS(BOOT)) dut (
    .clock     (clock),
    .reset     (reset),
    .rd_req    (rd_req),
    .addr_read (addr_read),
    .wr_req    (wr_req),
    .addr_write(addr_write),
    .data_write(data_write),
    .write_byte(write_byte),
    .out       (out),
    .rd_valid  (rd_valid),
    .written   (written),
    .ready     (ready),
    .range_err (range_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_req = 1'b0; wr_req = 1'b0; write_byte = 1'b0;
  endtask

  // Counts edges after release until ready; requests may be held active meanwhile.
  task automatic wait_ready(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("boot_no_rd_valid", 32'(rd_valid), 32'd0);
      chk("boot_no_written", 32'(written), 32'd0);
      if (ready) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic word_write(input logic [31:0] a, input logic [31:0] d);
    wr_req = 1'b1; addr_write = a; data_write = d; write_byte = 1'b0;
    tick();
    idle();
  endtask

  int          cyc;
  logic        e_rv, e_wr, e_re, r_oor, w_oor;
  logic [31:0] e_out;
  int          ridx, widx, lane;

  initial begin
    reset = 1'b1;
    idle();
    addr_read = '0; addr_write = '0; data_write = '0;
    tick(); tick();
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_written", 32'(written), 32'd0);
    chk("reset_range_err", 32'(range_err), 32'd0);
    chk("reset_out", out, 32'd0);

    // Boot with requests held active at 0x100; they must be ignored.
    rd_req = 1'b1; addr_read = 32'h100;
    wr_req = 1'b1; addr_write = 32'h100; data_write = 32'hA5A5_5A5A;
    reset = 1'b0;
    wait_ready(cyc);
    idle();
    chk("ready_latency", cyc, 32'd17);

    rd_req = 1'b1; addr_read = 32'h0;
    tick();
    chk("read0_valid", 32'(rd_valid), 32'd1);
    chk("read0_out", out, image[0]);
    addr_read = 32'h40;
    tick();
    chk("read64_valid", 32'(rd_valid), 32'd1);
    chk("read64_out", out, 32'hFFF9_FFF4);
    idle();
    tick();
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);
    chk("idle_out_hold", out, 32'hFFF9_FFF4);

    rd_req = 1'b1; addr_read = 32'h100;
    tick();
    idle();
    n_assert++;
    assert (out !== 32'hA5A5_5A5A) else begin
      n_fail++;
      $error("FAIL boot_write_dropped: observed %h expected not a5a55a5a", out);
    end

    // Word write then byte write to lane 2.
    wr_req = 1'b1; addr_write = 32'h200; data_write = 32'hDEAD_BEEF;
    tick();
    chk("word_written", 32'(written), 32'd1);
    write_byte = 1'b1; addr_write = 32'h202; data_write = 32'hFFFF_FF11;
    tick();
    chk("byte_written", 32'(written), 32'd1);
    idle();
    rd_req = 1'b1; addr_read = 32'h200;
    tick();
    idle();
    chk("byte_lane_merge", out, 32'hDE11_BEEF);
    chk("written_single", 32'(written), 32'd0);

    // Read-before-write on the same index.
    word_write(32'h300, 32'h0);
    rd_req = 1'b1; addr_read = 32'h300;
    wr_req = 1'b1; addr_write = 32'h300; data_write = 32'h1234_5678;
    tick();
    chk("rbw_old_data", out, 32'h0);
    chk("rbw_written", 32'(written), 32'd1);
    chk("rbw_rd_valid", 32'(rd_valid), 32'd1);
    wr_req = 1'b0;
    tick();
    idle();
    chk("rbw_new_data", out, 32'h1234_5678);

    // Out of range read and write together, then the last in-range word.
    rd_req = 1'b1; addr_read = 32'(4 * DEPTH);
    wr_req = 1'b1; addr_write = 32'(4 * DEPTH); data_write = 32'h5555_AAAA;
    tick();
    chk("oor_out", out, 32'h0);
    chk("oor_rd_valid", 32'(rd_valid), 32'd1);
    chk("oor_written", 32'(written), 32'd1);
    chk("oor_range_err", 32'(range_err), 32'd1);
    wr_req = 1'b0; addr_read = 32'(4 * DEPTH - 4);
    tick();
    chk("last_word_no_err", 32'(range_err), 32'd0);
    addr_read = 32'h0;
    tick();
    idle();
    chk("oor_ram0_intact", out, image[0]);

    // Randomized traffic over words 0..31 plus out-of-range addresses.
    for (int i = 0; i < BOOT; i++) model[i] = image[i];
    for (int i = BOOT; i < 32; i++) begin
      model[i] = $urandom;
      word_write(32'(i * 4), model[i]);
    end
    e_out = out;
    for (int n = 0; n < 300; n++) begin
      rd_req = 1'($urandom_range(0, 1));
      wr_req = 1'($urandom_range(0, 1));
      write_byte = 1'($urandom_range(0, 1));
      data_write = $urandom;
      if ($urandom_range(0, 7) == 0) addr_read = 32'(4 * DEPTH) + 32'($urandom_range(0, 4000));
      else addr_read = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) addr_write = 32'hFFFF_FFFC;
      else addr_write = 32'($urandom_range(0, 127));
      ridx = int'(addr_read / 4);
      widx = int'(addr_write / 4);
      lane = int'(addr_write % 4);
      r_oor = ridx >= DEPTH || addr_read >= 32'(4 * DEPTH);
      w_oor = addr_write >= 32'(4 * DEPTH);
      e_rv = rd_req;
      e_wr = wr_req;
      e_re = (rd_req && r_oor) || (wr_req && w_oor);
      if (rd_req) e_out = r_oor ? 32'h0 : model[ridx];
      if (wr_req && !w_oor) begin
        if (write_byte) model[widx][lane*8 +: 8] = data_write[7:0];
        else model[widx] = data_write;
      end
      tick();
      chk("rand_rd_valid", 32'(rd_valid), 32'(e_rv));
      chk("rand_written", 32'(written), 32'(e_wr));
      chk("rand_range_err", 32'(range_err), 32'(e_re));
      chk("rand_out", out, e_out);
    end
    idle();

    // Reset in the middle of a fresh boot copy.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("midboot_not_ready", 32'(ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("midboot_reset_ready", 32'(ready), 32'd0);
    chk("midboot_reset_out", out, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    wait_ready(cyc);
    chk("reboot_latency", cyc, 32'd17);
    for (int i = 0; i < BOOT; i++) begin
      rd_req = 1'b1; addr_read = 32'(i * 4);
      tick();
      chk("reboot_image", out, image[i]);
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
